// File: rtl/score_controller_if.sv
// Scoreboard control bundle: frame/hit/restart pulses in, committed scores and status out.
// Ports: fsync, hit_p1, hit_p2, restart (to controller); player_1_score, player_2_score,
//        game_over, winner, score_update (from controller). slave = controller side.
interface score_controller_if;
    logic       fsync;
    logic       hit_p1;
    logic       hit_p2;
    logic       restart;
    logic [3:0] player_1_score;
    logic [3:0] player_2_score;
    logic       game_over;
    logic [1:0] winner;
    logic       score_update;

    modport master (
        output fsync, hit_p1, hit_p2, restart,
        input  player_1_score, player_2_score, game_over, winner, score_update
    );

    modport slave (
        input  fsync, hit_p1, hit_p2, restart,
        output player_1_score, player_2_score, game_over, winner, score_update
    );
endinterface

// File: rtl/score_controller.sv
// Purpose: accumulate per-player hits, commit to displayed scores on fsync, hold game-over, auto-clear.
// Latency: 1 cycle from fsync/restart sample to registered outputs; CLEAR lasts one cycle.
// Backpressure: none; pulse inputs only, pending hits saturate at 3 per frame.
// Ports: pixel_clk, rst (async active-high), sc (score_controller_if.slave).
module score_controller #(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_FRAMES = 120
) (
    input  logic         pixel_clk,
    input  logic         rst,
    score_controller_if.slave sc
);

    localparam logic [1:0] ST_PLAY  = 2'd0;
    localparam logic [1:0] ST_OVER  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

    logic [1:0] state_q, state_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [1:0] pend1_q, pend1_d;
    logic [1:0] pend2_q, pend2_d;
    logic [7:0] hold_q, hold_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;
    logic       score_update_q, score_update_d;

    logic [4:0] sum1, sum2;
    logic [3:0] new1, new2;
    logic       do_clear;
    logic       changed;

    // Commit candidates, clamped so a score can never pass the winning digit.
    always_comb begin
        sum1 = {1'b0, score1_q} + {3'b000, pend1_q};
        sum2 = {1'b0, score2_q} + {3'b000, pend2_q};
        new1 = (sum1 > {1'b0, WIN}) ? WIN : sum1[3:0];
        new2 = (sum2 > {1'b0, WIN}) ? WIN : sum2[3:0];
    end

    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        pend1_d     = pend1_q;
        pend2_d     = pend2_q;
        hold_d      = hold_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        do_clear    = 1'b0;
        changed     = 1'b0;

        case (state_q)
            ST_PLAY: begin
                if (sc.restart) begin
                    do_clear = 1'b1;
                end else if (sc.fsync) begin
                    score1_d = new1;
                    score2_d = new2;
                    changed  = (new1 != score1_q) || (new2 != score2_q);
                    // Hits coincident with the commit belong to the next frame.
                    pend1_d  = {1'b0, sc.hit_p1};
                    pend2_d  = {1'b0, sc.hit_p2};
                    if ((new1 == WIN) || (new2 == WIN)) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                        winner_d    = {new2 == WIN, new1 == WIN};
                        hold_d      = HOLD;
                        // Nothing accumulates once the game is decided.
                        pend1_d     = 2'd0;
                        pend2_d     = 2'd0;
                    end
                end else begin
                    if (sc.hit_p1 && (pend1_q != 2'd3)) pend1_d = pend1_q + 2'd1;
                    if (sc.hit_p2 && (pend2_q != 2'd3)) pend2_d = pend2_q + 2'd1;
                end
            end
            ST_OVER: begin
                pend1_d = 2'd0;
                pend2_d = 2'd0;
                if (sc.restart) begin
                    do_clear = 1'b1;
                end else if (sc.fsync) begin
                    if (hold_q == 8'd1) begin
                        do_clear = 1'b1;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
            end
            ST_CLEAR: begin
                // Entry actions already applied; all inputs dropped this cycle.
                state_d = ST_PLAY;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase

        if (do_clear) begin
            state_d     = ST_CLEAR;
            changed     = (score1_q != 4'd0) || (score2_q != 4'd0);
            score1_d    = 4'd0;
            score2_d    = 4'd0;
            pend1_d     = 2'd0;
            pend2_d     = 2'd0;
            hold_d      = 8'd0;
            game_over_d = 1'b0;
            winner_d    = 2'b00;
        end

        // Changes on consecutive cycles (back-to-back fsync, commit then restart)
        // merge into a single pulse so the flag is never high two cycles running.
        score_update_d = changed && !score_update_q;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_PLAY;
            score1_q       <= 4'd0;
            score2_q       <= 4'd0;
            pend1_q        <= 2'd0;
            pend2_q        <= 2'd0;
            hold_q         <= 8'd0;
            game_over_q    <= 1'b0;
            winner_q       <= 2'b00;
            score_update_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            score1_q       <= score1_d;
            score2_q       <= score2_d;
            pend1_q        <= pend1_d;
            pend2_q        <= pend2_d;
            hold_q         <= hold_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            score_update_q <= score_update_d;
        end
    end

    assign sc.player_1_score = score1_q;
    assign sc.player_2_score = score2_q;
    assign sc.game_over      = game_over_q;
    assign sc.winner         = winner_q;
    assign sc.score_update   = score_update_q;

endmodule

// File: tb/tb_score_controller.sv
module tb_score_controller;

    localparam int W = 9;
    localparam int H = 3;

    logic pixel_clk;
    logic rst;
    int   checks;
    int   errors;

    score_controller_if sc_if ();

    score_controller #(.WIN_SCORE(W), .HOLD_FRAMES(H)) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .sc        (sc_if.slave)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    // Reference model: game described as scores, pending hits, frames left in game-over.
    int  m_s1, m_s2, m_p1, m_p2;
    int  m_over_left;   // >0 while the game-over hold is running
    bit  m_clearing;    // the one dead cycle after a clear
    int  m_win;
    bit  m_upd;

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
        m_over_left = 0; m_clearing = 0; m_win = 0; m_upd = 0;
    endtask

    task automatic model_clear(output bit ch);
        ch = (m_s1 != 0) || (m_s2 != 0);
        m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
        m_over_left = 0; m_win = 0; m_clearing = 1;
    endtask

    task automatic model_step(input bit fs, input bit h1, input bit h2, input bit rs);
        bit ch;
        int n1, n2;
        ch = 0;
        if (m_clearing) begin
            m_clearing = 0;
        end else if (rs) begin
            model_clear(ch);
        end else if (m_over_left > 0) begin
            m_p1 = 0; m_p2 = 0;
            if (fs) begin
                if (m_over_left == 1) model_clear(ch);
                else m_over_left = m_over_left - 1;
            end
        end else if (fs) begin
            n1 = min_i(m_s1 + m_p1, W);
            n2 = min_i(m_s2 + m_p2, W);
            ch = (n1 != m_s1) || (n2 != m_s2);
            m_s1 = n1; m_s2 = n2;
            m_p1 = h1; m_p2 = h2;
            if (n1 == W || n2 == W) begin
                m_win = ((n2 == W) ? 2 : 0) + ((n1 == W) ? 1 : 0);
                m_over_left = H;
                m_p1 = 0; m_p2 = 0;
            end
        end else begin
            m_p1 = min_i(m_p1 + h1, 3);
            m_p2 = min_i(m_p2 + h2, 3);
        end
        m_upd = ch && !m_upd;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".p1"},  int'(sc_if.player_1_score), m_s1);
        check({tag, ".p2"},  int'(sc_if.player_2_score), m_s2);
        check({tag, ".go"},  int'(sc_if.game_over), (m_over_left > 0) ? 1 : 0);
        check({tag, ".win"}, int'(sc_if.winner), m_win);
        check({tag, ".upd"}, int'(sc_if.score_update), int'(m_upd));
    endtask

    // One clock: drive inputs, clock edge, advance model, check 1 unit later.
    task automatic cyc(input bit fs, input bit h1, input bit h2, input bit rs, input string tag);
        sc_if.fsync   = fs;
        sc_if.hit_p1  = h1;
        sc_if.hit_p2  = h2;
        sc_if.restart = rs;
        @(posedge pixel_clk);
        model_step(fs, h1, h2, rs);
        #1;
        check_all(tag);
    endtask

    task automatic hits(input int n1, input int n2);
        for (int i = 0; i < ((n1 > n2) ? n1 : n2); i++)
            cyc(1'b0, i < n1, i < n2, 1'b0, "hits");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sc_if.fsync = 0; sc_if.hit_p1 = 0; sc_if.hit_p2 = 0; sc_if.restart = 0;
        rst = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        #4;

        // Basic commit: 3 and 1 hits.
        hits(3, 1);
        cyc(1, 0, 0, 0, "commit31");
        check("commit31.p1_const", int'(sc_if.player_1_score), 3);
        check("commit31.upd_const", int'(sc_if.score_update), 1);
        cyc(0, 0, 0, 0, "idle");

        // Saturation of pending hits, then a hit coincident with fsync.
        hits(5, 0);
        cyc(1, 0, 0, 0, "sat");
        check("sat.p1_const", int'(sc_if.player_1_score), 6);
        cyc(0, 0, 0, 0, "idle");
        cyc(1, 1, 0, 0, "carry_fs");
        cyc(0, 0, 0, 0, "idle");
        cyc(1, 0, 0, 0, "carry_commit");
        check("carry.p1_const", int'(sc_if.player_1_score), 7);

        // 8 then two hits -> clamp at 9, win for player 1; hits in OVER ignored.
        hits(1, 0);
        cyc(1, 0, 0, 0, "to8");
        hits(2, 0);
        cyc(1, 0, 0, 0, "win1");
        check("win1.win_const", int'(sc_if.winner), 1);
        check("win1.go_const", int'(sc_if.game_over), 1);
        hits(3, 3);
        for (int f = 0; f < H; f++) begin
            cyc(1, 1, 1, 0, "over_fs");
            cyc(0, 1, 0, 0, "over_idle");
        end
        check("afterhold.p1_const", int'(sc_if.player_1_score), 0);
        hits(1, 0);
        cyc(1, 0, 0, 0, "post_clear_hit");
        check("post_clear.p1_const", int'(sc_if.player_1_score), 1);

        // Tie: both reach 9 on the same commit, then restart during OVER.
        cyc(1, 0, 0, 1, "restart0");
        cyc(0, 0, 0, 0, "clear_cyc");
        hits(3, 3); cyc(1, 0, 0, 0, "tie_a");
        hits(3, 3); cyc(1, 0, 0, 0, "tie_b");
        hits(2, 2); cyc(1, 0, 0, 0, "tie_c");
        hits(1, 1); cyc(1, 0, 0, 0, "tie_win");
        check("tie.win_const", int'(sc_if.winner), 3);
        cyc(0, 0, 0, 0, "over_idle");
        cyc(1, 0, 0, 1, "restart_over");
        check("restart_over.go_const", int'(sc_if.game_over), 0);
        cyc(1, 1, 1, 0, "clear_drop");

        // Restart mid-PLAY with coincident fsync and hit.
        hits(2, 1); cyc(1, 0, 0, 0, "pre_rs");
        cyc(0, 0, 0, 0, "idle");
        hits(2, 2);
        cyc(1, 1, 1, 1, "restart_play");
        check("restart_play.upd_const", int'(sc_if.score_update), 1);
        cyc(0, 0, 0, 0, "clear_cyc");

        // Back-to-back fsyncs with carried hits.
        hits(1, 0);
        cyc(1, 1, 1, 0, "b2b_a");
        cyc(1, 0, 0, 0, "b2b_b");
        cyc(1, 0, 0, 0, "b2b_c");

        // Asynchronous reset while in OVER.
        for (int k = 0; k < 3; k++) begin
            hits(3, 0);
            cyc(1, 0, 0, 0, "to_over");
        end
        check("to_over.go_const", int'(sc_if.game_over), 1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst = 1'b0;
        hits(1, 1);
        cyc(1, 0, 0, 0, "after_rst");

        // Randomized play.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
